// File: rtl/copro32016_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | copro32016_pkg                                                       |
// | Shared types and helpers for the 32016 coprocessor SRAM controller.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package copro32016_pkg;

   localparam int LATENCY_MAX = 7;
   localparam int CNT_W       = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_RMW_RD = 2'd2,
      ST_WRITE  = 2'd3
   } state_e;

   // Byte lane n comes from new_w when be[n] is set, otherwise from old_w.
   function automatic logic [31:0] merge_be(input logic [3:0]  be,
                                            input logic [31:0] new_w,
                                            input logic [31:0] old_w);
      logic [31:0] m;
      m = old_w;
      for (int n = 0; n < 4; n++) begin
         if (be[n]) m[8*n +: 8] = new_w[8*n +: 8];
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram32_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram32_ctrl_if                                                       |
// | CPU-side IO bus between the 32016 bus logic and the SRAM controller. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sram32_ctrl_if #(
   parameter int AW = 19
);
   logic          sel;
   logic          io_rd;
   logic          io_wr;
   logic [AW-1:0] io_addr;
   logic [3:0]    io_be;
   logic [31:0]   io_di;
   logic [31:0]   io_q;
   logic          io_ready;

   modport master (
      output sel, io_rd, io_wr, io_addr, io_be, io_di,
      input  io_q, io_ready
   );

   modport slave (
      input  sel, io_rd, io_wr, io_addr, io_be, io_di,
      output io_q, io_ready
   );
endinterface
`default_nettype wire

// File: rtl/sram32_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram32_ctrl                                                          |
// | Word read / posted write / read-modify-write controller for a        |
// | 512Kx32 asynchronous SRAM with configurable access latency.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sram32_ctrl
   import copro32016_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int AW      = 19
) (
   input  wire logic          clk,
   input  wire logic          rst_b,
   sram32_ctrl_if.slave       bus,
   output logic               ram_cs_b,
   output logic               ram_oe_b,
   output logic               ram_wr_b,
   output logic               ram_ub_b,
   output logic               ram_lb_b,
   output logic [AW-1:0]      ram_addr,
   output logic [31:0]        ram_dout,
   output logic               ram_doe,
   input  wire logic [31:0]   ram_din
);

   localparam logic [CNT_W-1:0] LAT =
      CNT_W'((LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY);

   state_e            state_q,    state_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic              busy_wr_q,  busy_wr_d;
   logic              io_ready_q, io_ready_d;
   logic [31:0]       io_q_q,     io_q_d;
   logic              cs_b_q,     cs_b_d;
   logic              oe_b_q,     oe_b_d;
   logic              wr_b_q,     wr_b_d;
   logic              ub_b_q,     ub_b_d;
   logic              lb_b_q,     lb_b_d;
   logic [AW-1:0]     addr_q,     addr_d;
   logic [31:0]       dout_q,     dout_d;
   logic              doe_q,      doe_d;
   logic              accept;

   // The io_ready term stops a strobe still held in the completion cycle from restarting.
   assign accept = bus.sel & (bus.io_rd | bus.io_wr) & ~io_ready_q & ~busy_wr_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         busy_wr_q  <= 1'b0;
         io_ready_q <= 1'b0;
         io_q_q     <= '0;
         cs_b_q     <= 1'b1;
         oe_b_q     <= 1'b1;
         wr_b_q     <= 1'b1;
         ub_b_q     <= 1'b1;
         lb_b_q     <= 1'b1;
         addr_q     <= '0;
         dout_q     <= '0;
         doe_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_wr_q  <= busy_wr_d;
         io_ready_q <= io_ready_d;
         io_q_q     <= io_q_d;
         cs_b_q     <= cs_b_d;
         oe_b_q     <= oe_b_d;
         wr_b_q     <= wr_b_d;
         ub_b_q     <= ub_b_d;
         lb_b_q     <= lb_b_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         doe_q      <= doe_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busy_wr_d  = busy_wr_q;
      io_ready_d = 1'b0;
      io_q_d     = io_q_q;
      cs_b_d     = cs_b_q;
      oe_b_d     = oe_b_q;
      wr_b_d     = wr_b_q;
      ub_b_d     = ub_b_q;
      lb_b_d     = lb_b_q;
      addr_d     = addr_q;
      dout_d     = dout_q;
      doe_d      = doe_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d = '0;
               if (bus.io_rd || (bus.io_be != 4'h0 && bus.io_be != 4'hF)) begin
                  state_d = bus.io_rd ? ST_READ : ST_RMW_RD;
                  addr_d  = bus.io_addr;
                  cs_b_d  = 1'b0;
                  oe_b_d  = 1'b0;
                  wr_b_d  = 1'b1;
                  ub_b_d  = 1'b0;
                  lb_b_d  = 1'b0;
                  doe_d   = 1'b0;
               end else if (bus.io_be == 4'hF) begin
                  state_d    = ST_WRITE;
                  addr_d     = bus.io_addr;
                  dout_d     = bus.io_di;
                  cs_b_d     = 1'b0;
                  oe_b_d     = 1'b1;
                  wr_b_d     = 1'b0;
                  ub_b_d     = 1'b0;
                  lb_b_d     = 1'b0;
                  doe_d      = 1'b1;
                  busy_wr_d  = 1'b1;
                  io_ready_d = 1'b1;
               end else begin
                  io_ready_d = 1'b1;
               end
            end
         end

         ST_READ: begin
            if (cnt_q == LAT) begin
               state_d    = ST_IDLE;
               io_q_d     = ram_din;
               io_ready_d = 1'b1;
               cs_b_d     = 1'b1;
               oe_b_d     = 1'b1;
               ub_b_d     = 1'b1;
               lb_b_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RMW_RD: begin
            // Merge uses io_di still held by the CPU, since io_ready has not yet been given.
            if (cnt_q == LAT) begin
               state_d    = ST_WRITE;
               cnt_d      = '0;
               dout_d     = merge_be(bus.io_be, bus.io_di, ram_din);
               oe_b_d     = 1'b1;
               wr_b_d     = 1'b0;
               doe_d      = 1'b1;
               busy_wr_d  = 1'b1;
               io_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_WRITE: begin
            if (cnt_q == LAT) begin
               state_d   = ST_IDLE;
               busy_wr_d = 1'b0;
               cs_b_d    = 1'b1;
               oe_b_d    = 1'b1;
               wr_b_d    = 1'b1;
               ub_b_d    = 1'b1;
               lb_b_d    = 1'b1;
               doe_d     = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.io_q     = io_q_q;
   assign bus.io_ready = io_ready_q;
   assign ram_cs_b     = cs_b_q;
   assign ram_oe_b     = oe_b_q;
   assign ram_wr_b     = wr_b_q;
   assign ram_ub_b     = ub_b_q;
   assign ram_lb_b     = lb_b_q;
   assign ram_addr     = addr_q;
   assign ram_dout     = dout_q;
   assign ram_doe      = doe_q;

endmodule
`default_nettype wire

// File: tb/tb_sram32_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sram32_ctrl                                                       |
// | Scoreboard bench: three controllers (LATENCY 1, 0, 7) with SRAM pads.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sram32_ctrl;

   localparam int AW = 19;

   typedef struct packed {
      logic [1:0]  k;
      logic        is_rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic mem_init = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   logic          t_sel [3];
   logic          t_rd  [3];
   logic          t_wr  [3];
   logic [AW-1:0] t_addr[3];
   logic [3:0]    t_be  [3];
   logic [31:0]   t_di  [3];
   logic          t_ready[3];
   logic [31:0]   t_q   [3];
   logic          t_cs  [3];
   logic          t_oe  [3];
   logic          t_wr_b[3];
   logic          t_ub  [3];
   logic          t_lb  [3];
   logic [AW-1:0] t_raddr[3];
   logic [31:0]   t_dout[3];
   logic          t_doe [3];
   logic [31:0]   t_din [3];

   exp_t        exp_q[$];
   string       dq_name[$];
   logic [31:0] dq_act[$];
   logic [31:0] dq_exp[$];
   logic [31:0] last_rd[3];

   logic [31:0] refmem [64];
   int          free   [3];
   logic [31:0] sram_mem [64];
   logic        sram_vld [64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
   endfunction

   function automatic logic [31:0] init_pat(input logic [AW-1:0] a);
      case (a)
         19'h10:  return 32'hDEAD_BEEF;
         19'h30:  return 32'h1122_3344;
         default: return {a[7:0], ~a[7:0], a[7:0] ^ 8'h5A, 8'hC3};
      endcase
   endfunction

   // Pad + SRAM model for instance 0; the others see a fixed address pattern.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) sram_vld[i] <= 1'b0;
      end else if (!t_cs[0] && !t_wr_b[0]) begin
         sram_mem[t_raddr[0][5:0]] <= t_doe[0] ? t_dout[0] : 32'hFFFF_FFFF;
         sram_vld[t_raddr[0][5:0]] <= 1'b1;
      end
   end

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int L = (k == 0) ? 1 : ((k == 1) ? 0 : 7);
      sram32_ctrl_if #(.AW(AW)) bus ();
      assign bus.sel     = t_sel[k];
      assign bus.io_rd   = t_rd[k];
      assign bus.io_wr   = t_wr[k];
      assign bus.io_addr = t_addr[k];
      assign bus.io_be   = t_be[k];
      assign bus.io_di   = t_di[k];
      assign t_ready[k]  = bus.io_ready;
      assign t_q[k]      = bus.io_q;

      sram32_ctrl #(.LATENCY(L), .AW(AW)) u_dut (
         .clk      (clk),
         .rst_b    (rst_b),
         .bus      (bus.slave),
         .ram_cs_b (t_cs[k]),
         .ram_oe_b (t_oe[k]),
         .ram_wr_b (t_wr_b[k]),
         .ram_ub_b (t_ub[k]),
         .ram_lb_b (t_lb[k]),
         .ram_addr (t_raddr[k]),
         .ram_dout (t_dout[k]),
         .ram_doe  (t_doe[k]),
         .ram_din  (t_din[k])
      );

      if (k == 0) begin : g_pad_mem
         assign t_din[k] = (!t_cs[k] && !t_oe[k])
                           ? (sram_vld[t_raddr[k][5:0]] ? sram_mem[t_raddr[k][5:0]]
                                                        : init_pat(t_raddr[k]))
                           : 32'hFFFF_FFFF;
      end else begin : g_pad_pat
         assign t_din[k] = (!t_cs[k] && !t_oe[k]) ? init_pat(t_raddr[k]) : 32'hFFFF_FFFF;
      end
   end

   task automatic tally(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s[%0d]: got %h, wanted %h", nm, k, act, exp);
   endtask

   // Monitor: every comparison is made here, against expectations queued by the stimulus.
   always @(negedge clk) begin
      exp_t e;
      int   idx;
      while (dq_name.size() > 0) begin
         tally(dq_name.pop_front(), 0, dq_act.pop_front(), dq_exp.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
         if (!rst_b) begin
            last_rd[k] = '0;
         end else begin
            idx = -1;
            foreach (exp_q[i]) if (idx < 0 && exp_q[i].k == 2'(k)) idx = i;
            if (t_ready[k]) begin
               if (idx < 0) begin
                  tally("unexpected_ready", k, 32'd1, 32'd0);
               end else begin
                  e = exp_q[idx];
                  exp_q.delete(idx);
                  tally("ready_cycle", k, cyc, e.cyc);
                  if (e.is_rd) begin
                     tally("read_data", k, t_q[k], e.data);
                     last_rd[k] = e.data;
                  end else begin
                     tally("io_q_hold", k, t_q[k], last_rd[k]);
                  end
               end
            end else if (idx >= 0 && cyc > exp_q[idx].cyc + 4) begin
               tally("ready_timeout", k, cyc, exp_q[idx].cyc);
               exp_q.delete(idx);
            end
         end
      end
      if (rst_b && (!t_wr_b[0] || t_doe[0]))
         tally("write_strobes", 0, {29'd0, t_cs[0], t_wr_b[0], t_doe[0]}, 32'd1);
   end

   task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      dq_name.push_back(nm);
      dq_act.push_back(act);
      dq_exp.push_back(exp);
   endtask

   // Called at a negedge; returns at the negedge where io_ready is seen (or after a bound).
   task automatic issue(input int k, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] di, output int n_cs);
      exp_t        e;
      int          T;
      int          L;
      logic [31:0] mask;
      L = lat(k);
      t_sel[k] = 1'b1; t_rd[k] = rd; t_wr[k] = wr;
      t_addr[k] = a; t_be[k] = be; t_di[k] = di;
      T = (cyc + 1 > free[k]) ? cyc + 1 : free[k];
      e.k = 2'(k); e.is_rd = rd; e.data = '0;
      if (rd) begin
         e.data = (k == 0) ? refmem[a[5:0]] : init_pat(a);
         e.cyc = T + L + 1;
         free[k] = T + L + 3;
      end else if (be == 4'hF) begin
         if (k == 0) refmem[a[5:0]] = di;
         e.cyc = T;
         free[k] = T + L + 2;
      end else if (be == 4'h0) begin
         e.cyc = T;
         free[k] = T + 2;
      end else begin
         mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
         if (k == 0) refmem[a[5:0]] = (refmem[a[5:0]] & ~mask) | (di & mask);
         e.cyc = T + L + 1;
         free[k] = T + 2 * L + 3;
      end
      exp_q.push_back(e);
      n_cs = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (t_ready[k]) break;
         if (!t_cs[k]) n_cs++;
      end
      t_rd[k] = 1'b0;
      t_wr[k] = 1'b0;
   endtask

   task automatic watch_write(input logic [AW-1:0] a, input logic [31:0] d,
                              output int n_low, output int n_ok);
      n_low = 0; n_ok = 0;
      for (int n = 0; n < 20; n++) begin
         if (t_wr_b[0]) break;
         n_low++;
         if (!t_cs[0] && t_doe[0] && t_dout[0] == d && t_raddr[0] == a) n_ok++;
         @(negedge clk);
      end
   endtask

   task automatic reset_checks();
      for (int k = 0; k < 3; k++) begin
         dchk("rst_strobes", {27'd0, t_cs[k], t_oe[k], t_wr_b[k], t_ub[k], t_lb[k]}, 32'h1F);
         dchk("rst_doe_ready", {30'd0, t_doe[k], t_ready[k]}, 32'd0);
         dchk("rst_io_q", t_q[k], 32'd0);
         dchk("rst_addr_dout", {13'd0, t_raddr[k]} | t_dout[k], 32'd0);
      end
   endtask

   initial begin
      int          n, nl, nok, r;
      logic [3:0]  be;
      logic [AW-1:0] a;
      logic [31:0] d;
      for (int k = 0; k < 3; k++) begin
         t_sel[k] = 1'b0; t_rd[k] = 1'b0; t_wr[k] = 1'b0;
         t_addr[k] = '0; t_be[k] = '0; t_di[k] = '0; free[k] = 0;
      end
      for (int i = 0; i < 64; i++) refmem[i] = init_pat(AW'(i));
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      reset_checks();
      rst_b = 1'b1;
      @(negedge clk);

      // Plain read
      issue(0, 1'b1, 1'b0, 19'h10, 4'hF, 32'h0, n);
      dchk("read_strobe_cycles", n, 32'd2);
      @(negedge clk);
      // Posted full write: strobes and data held for the whole write phase
      issue(0, 1'b0, 1'b1, 19'h20, 4'hF, 32'h1234_5678, n);
      watch_write(19'h20, 32'h1234_5678, nl, nok);
      dchk("wr_phase_cycles", nl, 32'd2);
      dchk("wr_phase_stable", nok, 32'd2);
      // Partial write via read-modify-write, then read it back
      issue(0, 1'b0, 1'b1, 19'h30, 4'b0101, 32'hAABB_CCDD, n);
      issue(0, 1'b1, 1'b0, 19'h30, 4'h0, 32'h0, n);
      dchk("rmw_result_model", refmem[6'h30], 32'h11BB_33DD);
      issue(0, 1'b1, 1'b0, 19'h20, 4'h0, 32'h0, n);
      // Back-to-back: read issued in the write's io_ready cycle
      issue(0, 1'b0, 1'b1, 19'h40, 4'hF, 32'h0BAD_F00D, n);
      issue(0, 1'b1, 1'b0, 19'h40, 4'h0, 32'h0, n);

      // Reset during the write phase
      issue(0, 1'b0, 1'b1, 19'h21, 4'hF, 32'hCAFE_F00D, n);
      #2 rst_b = 1'b0;
      #1 dchk("midrst_strobes", {27'd0, t_cs[0], t_oe[0], t_wr_b[0], t_ub[0], t_lb[0]}, 32'h1F);
      dchk("midrst_doe_ready", {30'd0, t_doe[0], t_ready[0]}, 32'd0);
      repeat (3) @(negedge clk);
      reset_checks();
      rst_b = 1'b1;
      for (int k = 0; k < 3; k++) free[k] = 0;
      for (int i = 0; i < 64; i++) refmem[i] = sram_vld[i] ? sram_mem[i] : init_pat(AW'(i));
      @(negedge clk);
      issue(0, 1'b1, 1'b0, 19'h10, 4'h0, 32'h0, n);

      // LATENCY 0 and 7 reads, and be=0 writes that must not touch the SRAM
      for (int k = 1; k < 3; k++) begin
         issue(k, 1'b1, 1'b0, 19'h05, 4'h0, 32'h0, n);
         dchk("lat_read_strobes", n, 32'(lat(k) + 1));
         issue(k, 1'b0, 1'b1, 19'h06, 4'h0, 32'h1, n);
         dchk("be0_no_strobe", {31'd0, t_cs[k]} | 32'(n), 32'd1);
      end
      issue(0, 1'b0, 1'b1, 19'h07, 4'h0, 32'hFFFF_FFFF, n);
      dchk("be0_no_strobe", {31'd0, t_cs[0]} | 32'(n), 32'd1);

      // Randomized traffic with unselected gap cycles
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 2);
         for (int g = 0; g < r; g++) begin
            t_sel[0] = 1'b0;
            t_rd[0] = 1'($urandom);
            t_wr[0] = 1'($urandom);
            @(negedge clk);
         end
         a = AW'($urandom_range(0, 63));
         d = $urandom;
         r = $urandom_range(0, 9);
         if (r < 4)      issue(0, 1'b1, (r == 0), a, 4'($urandom), d, n);
         else if (r < 7) issue(0, 1'b0, 1'b1, a, 4'hF, d, n);
         else if (r == 7) issue(0, 1'b0, 1'b1, a, 4'h0, d, n);
         else begin
            be = 4'($urandom_range(1, 14));
            issue(0, 1'b0, 1'b1, a, be, d, n);
         end
      end
      for (int i = 0; i < 20; i++) begin
         issue(1 + (i % 2), 1'b1, 1'($urandom), AW'($urandom_range(0, 63)), 4'hF, $urandom, n);
      end

      repeat (40) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
